ram_responder: RTL



---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_array.sv | 27 ++
 rtl/ram_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and default geometry for the RAM responder slice.
package ram_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int              ADDR_W_DEF     = 8;
    localparam int              DATA_W_DEF     = 8;
    localparam logic [7:0]      INIT_VALUE_DEF = 8'h00;

endpackage

// File: rtl/ram_array.sv
// Purpose: 2^ADDR_W x DATA_W storage, one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge; read is zero-cycle.
// Backpressure: none; every enabled write is taken.
module ram_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_vld,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // No reset on the array itself: the responder's CLEAR phase initialises it.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/ram_responder.sv
// Purpose: RAM responder; clears the array, loads a program image, then serves the CPU. Optional RAM_WRITE_PROTECT_EN.
// Latency: clear 2^ADDR_W cycles; load 1 byte/cycle; CPU read 0 cycles, write 1 edge.
// Backpressure: ld_ready only in LOAD; cpu_hold stalls the processor until the image is in place.
module ram_responder
    import ram_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VALUE = INIT_VALUE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    input  logic              ram_we,
    output logic [DATA_W-1:0] ram_out,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   load_len,
    output logic              wp_violation
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_W:0]   LEN_ONE   = 1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] ld_ptr;
    logic              ld_fire;
    logic              ld_done;
    logic              wp_block;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdat;
    logic [DATA_W-1:0] mem_rdat;

    assign ld_ready = (state == ST_LOAD);
    assign cpu_hold = (state != ST_RUN);
    assign ld_fire  = ld_valid && ld_ready;
    // A full-depth image ends the load on its own so ld_ptr never wraps.
    assign ld_done  = ld_fire && (ld_last || (ld_ptr == LAST_ADDR));
    assign ram_out  = (state == ST_RUN) ? mem_rdat : '0;

`ifdef RAM_WRITE_PROTECT_EN
    assign wp_block = ({1'b0, ram_addr} < load_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_violation <= 1'b0;
        end else if ((state == ST_RUN) && ram_we && wp_block) begin
            wp_violation <= 1'b1;
        end
    end
`else
    assign wp_block     = 1'b0;
    assign wp_violation = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus write-port steering: clear pattern, loader, or CPU.
    always_comb begin
        state_n   = state;
        mem_we    = 1'b0;
        mem_waddr = ram_addr;
        mem_wdat  = ram_data;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_wdat  = INIT_VALUE;
                if (clr_ptr == LAST_ADDR) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mem_we    = ld_fire;
                mem_waddr = ld_ptr;
                mem_wdat  = ld_data;
                if (ld_done) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = ram_we && !wp_block;
            end
            default: begin
                state_n = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr  <= '0;
            ld_ptr   <= '0;
            load_len <= '0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + PTR_ONE;
            end
            if (ld_fire && !ld_done) begin
                ld_ptr <= ld_ptr + PTR_ONE;
            end
            if (ld_done) begin
                load_len <= {1'b0, ld_ptr} + LEN_ONE;
            end
        end
    end

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram_array (
        .clk     (clk),
        .wr_vld  (mem_we),
        .wr_addr (mem_waddr),
        .wr_dat  (mem_wdat),
        .rd_addr (ram_addr),
        .rd_dat  (mem_rdat)
    );

endmodule
